// File: rtl/fir_pkg.sv
// Shared FIR definitions: datapath widths, serial schedule and feeder state encoding.
package fir_pkg;

   localparam int FIR_DW            = 12;
   localparam int FIR_TAPS          = 16;
   localparam int FIR_SERIAL_CYCLES = 8;
   localparam int FEEDER_DEPTH      = 8;

   typedef enum logic [1:0] {
      NORM  = 2'd0,
      DRAIN = 2'd1,
      ZERO  = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/sync_fifo_rw.sv
// Small synchronous FIFO with combinational head and registered occupancy.
// Push and pop may coincide; there is no bypass, so an entry pushed into an
// empty FIFO becomes visible on the head one cycle later.
module sync_fifo_rw #(
   parameter int DW    = 12,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [DW-1:0]            i_din,
   output logic [DW-1:0]            o_head,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   // Guard against overflow/underflow so the occupancy can never leave 0..DEPTH.
   assign w_do_push = i_push && (r_level != LW'(DEPTH));
   assign w_do_pop  = i_pop  && (r_level != '0);

   // Storage array; contents are not reset, a reset simply empties the pointers.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/fir_serial_feeder.sv
// Input stage for the serial FIR: buffers samples and strobes them out no
// faster than one per SPACING clocks. A flush drains the buffer and then
// feeds TAPS zeros so the FIR delay line is emptied.
module fir_serial_feeder
   import fir_pkg::*;
#(
   parameter int DW      = FIR_DW,
   parameter int DEPTH   = FEEDER_DEPTH,
   parameter int SPACING = FIR_SERIAL_CYCLES,
   parameter int TAPS    = FIR_TAPS
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   input  logic [DW-1:0]            s_data,
   output logic                     s_ready,
   input  logic                     flush_req,
   output logic                     flush_busy,
   output logic                     en,
   output logic [DW-1:0]            xin,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int LW  = $clog2(DEPTH) + 1;
   localparam int SPW = (SPACING > 1) ? $clog2(SPACING) : 1;
   localparam int ZW  = (TAPS > 1) ? $clog2(TAPS) : 1;

   feeder_state_t r_state;
   feeder_state_t w_state_next;
   logic [ZW-1:0] r_zcnt;
   logic [ZW-1:0] w_zcnt_next;
   logic [SPW-1:0] r_sp;
   logic          r_run;
   logic          r_en;
   logic [DW-1:0] r_xin;
   logic          w_fire;
   logic          w_push;
   logic          w_pop;
   logic          w_ready;
   logic [DW-1:0] w_head;
   logic [LW-1:0] w_level;

   sync_fifo_rw #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (s_data),
      .o_head  (w_head),
      .o_level (w_level)
   );

   // Acceptance is held off until the first clock after reset release.
   assign w_ready = r_run && (w_level != LW'(DEPTH)) && (r_state == NORM);
   assign w_push  = s_valid && w_ready;
   assign w_fire  = (r_sp == '0) && ((r_state == ZERO) || (w_level != '0));
   assign w_pop   = w_fire && (r_state != ZERO);

   // Next-state logic: flush request, drain completion, zero-injection count.
   always_comb begin
      w_state_next = r_state;
      w_zcnt_next  = r_zcnt;
      case (r_state)
         NORM: begin
            if (flush_req) w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_level == '0) begin
               w_state_next = ZERO;
               w_zcnt_next  = '0;
            end
         end
         ZERO: begin
            if (w_fire) begin
               w_zcnt_next = r_zcnt + 1'b1;
               if (r_zcnt == ZW'(TAPS - 1)) w_state_next = NORM;
            end
         end
         default: w_state_next = NORM;
      endcase
   end

   // State, zero counter and the post-reset run flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= NORM;
         r_zcnt  <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_zcnt  <= w_zcnt_next;
         r_run   <= 1'b1;
      end
   end

   // Strobe generation with minimum spacing; xin holds its value between strobes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_en  <= 1'b0;
         r_xin <= '0;
         r_sp  <= '0;
      end else begin
         r_en <= w_fire;
         if (w_fire) begin
            r_xin <= (r_state == ZERO) ? '0 : w_head;
            r_sp  <= SPW'(SPACING - 1);
         end else if (r_sp != '0) begin
            r_sp <= r_sp - 1'b1;
         end
      end
   end

   assign s_ready    = w_ready;
   assign flush_busy = (r_state == DRAIN) || (r_state == ZERO);
   assign en         = r_en;
   assign xin        = r_xin;
   assign level      = w_level;

endmodule
